cdc_src_arbiter: RTL and testbench
==================================

# cdc_src_arbiter

Round-robin arbiter that shares one two-phase clock-domain-crossing channel among `REQ_NUM` requesters in the source clock domain. It sits directly in front of the CDC source port. It grants one requester at a time, for a burst of up to `MAX_BURST` beats. Each beat is tagged with the requester index and driven through a one-entry output register, so the CDC input is fully registered.

## Interface
- `REQ_NUM`, default 4: number of requesters, 1..16.
- `DATA_WIDTH`, default 32: payload width per requester.
- `MAX_BURST`, default 4: maximum beats per grant, 1..255.
- `ID_WIDTH`, derived (localparam): `$clog2(REQ_NUM)`, forced to 1 when `REQ_NUM`==1.

Ports:
- `clk_i`  in  1  source-domain clock. One clock; all logic is on its rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  REQ_NUM  per-requester valid.
- `req_ready_o`  out  REQ_NUM  per-requester ready. At most one bit is set.
- `req_data_i`  in  REQ_NUM*DATA_WIDTH  payloads. Requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- `cdc_valid_o`  out  1  valid toward the CDC source port.
- `cdc_ready_i`  in  1  ready from the CDC source port.
- `cdc_data_o`  out  ID_WIDTH+DATA_WIDTH  {id, payload}.
- `gnt_id_o`  out  ID_WIDTH  index of the current or most recent grant.
- `busy_o`  out  1  high in LOCK state or while `cdc_valid_o` is high.

## Operation
- State machine with two states.
  - IDLE: no grant is active and all `req_ready_o` are 0.
  - LOCK: requester `gnt_q` holds the channel.
- IDLE → LOCK when any `req_valid_i` bit is set.
  - Winner is the first set bit, scanning upward from (`last_q`+1) mod `REQ_NUM` with wrap-around.
  - On entry: `gnt_q` ← winner, `beat_cnt` ← 0.
- In LOCK:
  - `obuf_free` = !`cdc_valid_o` || `cdc_ready_i`.
  - `req_ready_o[gnt_q]` = `obuf_free`. All other ready bits are 0.
  - A beat transfers when `req_valid_i[gnt_q]` && `req_ready_o[gnt_q]`.
- On each beat:
  - `cdc_data_o` ← {`gnt_q`, `req_data_i` slice}.
  - `cdc_valid_o` ← 1.
  - `beat_cnt` ← `beat_cnt`+1.
- LOCK → IDLE, with `last_q` ← `gnt_q`, when either:
  - a beat transfers with `beat_cnt` == `MAX_BURST`-1, or
  - `req_valid_i[gnt_q]` == 0 (end of request).
- Output register:
  - `cdc_valid_o` clears on `cdc_ready_i` when no new beat loads that cycle.
  - If a drain and a load happen in the same cycle, the new data replaces the old and `cdc_valid_o` stays 1.
  - `cdc_data_o` holds its value while `cdc_valid_o`=1 and `cdc_ready_i`=0.
- `gnt_id_o` = `gnt_q`.
- Width rule: `beat_cnt` is 8 bits. It is compared, never wrapped, since `MAX_BURST` ≤ 255.
- Protocol rule on requesters: a requester does not drop `req_valid_i` or change its data while valid is high and ready is low.

## Timing
- Reset values: `req_ready_o`=0, `cdc_valid_o`=0, `cdc_data_o`=0, `gnt_id_o`=0, `busy_o`=0, state IDLE, `last_q`=`REQ_NUM`-1 (so requester 0 has first priority).
- Latency from `req_valid_i` rising in IDLE at cycle t:
  - `req_ready_o` high at t+1, if the output register is free.
  - `cdc_valid_o` high at t+2.
- Grant changeover costs exactly one IDLE bubble cycle.
- Within a burst, one beat per cycle is accepted while `cdc_ready_i` stays high.
- `MAX_BURST`=1: every beat is followed by an IDLE cycle and re-arbitration.
- Reset mid-operation: the grant, the burst count and any un-drained output beat are discarded. Outputs return to their reset values immediately (asynchronous). The CDC channel is reset by the same reset.

## Test plan
- Reset, then only requester 2 valid with data 0xA5 and `cdc_ready_i`=1:
  - `req_ready_o`=4'b0100 at t+1.
  - `cdc_valid_o`=1 at t+2 with `cdc_data_o`={2'd2, 32'hA5}.
- All 4 requesters valid continuously, `MAX_BURST`=1, `cdc_ready_i`=1: grant order is 0,1,2,3,0,… with one IDLE cycle between grants.
- Requester 1 valid for 6 beats, `MAX_BURST`=4:
  - Beats 1–4 on consecutive cycles, then IDLE, then beats 5–6 in a new grant.
  - `cdc_data_o` id stays 1 throughout.
- `cdc_ready_i` held 0 for 5 cycles after the first beat:
  - `cdc_valid_o` and `cdc_data_o` are held stable.
  - `req_ready_o` is 0.
  - No beat is lost or duplicated once ready returns.
- Requester 0 deasserts valid after 2 of `MAX_BURST`=4 beats: LOCK exits the next cycle, `last_q`=0, and requester 1 (valid) wins the next grant.
- Assert `rst_n_i` low while a beat is pending in the output register: `cdc_valid_o`=0 and `req_ready_o`=0 asynchronously; after release, requester 0 has priority.

Source files
------------

// File: rtl/cdc_src_arbiter.sv
// cdc_src_arbiter: round-robin sharing of one CDC source port
// among REQ_NUM requesters, with a registered {id, payload} output.
module cdc_src_arbiter #(
   parameter int REQ_NUM    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   localparam int ID_WIDTH  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [REQ_NUM-1:0]             req_valid_i,
   output logic [REQ_NUM-1:0]             req_ready_o,
   input  logic [REQ_NUM*DATA_WIDTH-1:0]  req_data_i,
   output logic                           cdc_valid_o,
   input  logic                           cdc_ready_i,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_data_o,
   output logic [ID_WIDTH-1:0]            gnt_id_o,
   output logic                           busy_o
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(REQ_NUM - 1);

   state_e                         state_q;
   logic [ID_WIDTH-1:0]            gnt_q;
   logic [ID_WIDTH-1:0]            last_q;
   logic [7:0]                     beat_cnt_q;
   logic                           cdc_valid_q;
   logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_data_q;

   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  any_valid;
   logic [ID_WIDTH-1:0]   win_id;
   logic [ID_WIDTH-1:0]   hi_id;
   logic                  hi_found;
   logic [ID_WIDTH-1:0]   lo_id;
   logic                  obuf_free;
   logic                  beat;
   logic                  burst_end;
   logic [REQ_NUM-1:0]    ready;

   assign any_valid = |req_valid_i;
   assign obuf_free = !cdc_valid_q || cdc_ready_i;
   assign beat      = (state_q == LOCK) && sel_valid && obuf_free;
   assign burst_end = beat && (beat_cnt_q == LAST_BEAT);

   // Pick the granted requester's valid and payload.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (gnt_q == ID_WIDTH'(k)) begin
            sel_valid = req_valid_i[k];
            sel_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Rotating priority: lowest valid index above last_q, else lowest overall.
   always_comb begin
      hi_id    = '0;
      hi_found = 1'b0;
      lo_id    = '0;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         if (req_valid_i[k]) begin
            lo_id = ID_WIDTH'(k);
            if (ID_WIDTH'(k) > last_q) begin
               hi_id    = ID_WIDTH'(k);
               hi_found = 1'b1;
            end
         end
      end
      win_id = hi_found ? hi_id : lo_id;
   end

   // Only the granted requester sees ready, and only when the buffer can take a beat.
   always_comb begin
      ready = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (state_q == LOCK && obuf_free && gnt_q == ID_WIDTH'(k)) begin
            ready[k] = 1'b1;
         end
      end
   end

   // Grant FSM, burst counter and the one-entry output register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         last_q      <= LAST_ID;
         beat_cnt_q  <= '0;
         cdc_valid_q <= 1'b0;
         cdc_data_q  <= '0;
      end else begin
         if (beat) begin
            cdc_valid_q <= 1'b1;
            cdc_data_q  <= {gnt_q, sel_data};
         end else if (cdc_ready_i) begin
            cdc_valid_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (any_valid) begin
                  state_q    <= LOCK;
                  gnt_q      <= win_id;
                  beat_cnt_q <= '0;
               end
            end
            LOCK: begin
               if (!sel_valid || burst_end) begin
                  state_q <= IDLE;
                  last_q  <= gnt_q;
               end else if (beat) begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
               end
            end
         endcase
      end
   end

   assign req_ready_o = ready;
   assign cdc_valid_o = cdc_valid_q;
   assign cdc_data_o  = cdc_data_q;
   assign gnt_id_o    = gnt_q;
   assign busy_o      = (state_q == LOCK) || cdc_valid_q;

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// tb_cdc_src_arbiter: randomized and directed checks of the
// arbiter against a queue-based transaction model.
module tb_cdc_src_arbiter;

   localparam int RN = 4;
   localparam int DW = 32;
   localparam int MB = 4;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [RN-1:0]     vld;
   logic [RN-1:0]     rdy;
   logic [RN*DW-1:0]  dat;
   logic              cvld;
   logic              crdy;
   logic [IW+DW-1:0]  cdat;
   logic [IW-1:0]     gid;
   logic              busy;

   always #5 clk = ~clk;

   cdc_src_arbiter #(
      .REQ_NUM    (RN),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (vld),
      .req_ready_o (rdy),
      .req_data_i  (dat),
      .cdc_valid_o (cvld),
      .cdc_ready_i (crdy),
      .cdc_data_o  (cdat),
      .gnt_id_o    (gid),
      .busy_o      (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model: owner of the channel (-1 = none), beats used,
   // previous owner, displayed grant, and the output register contents.
   int               own;
   int               used;
   int               last;
   int               gnt;
   logic [IW+DW-1:0] outq[$];
   logic [IW+DW-1:0] last_out;
   logic [RN-1:0]    hold;
   logic [RN-1:0]    exp_rdy;
   int               hs_cnt[RN];

   task automatic model_reset();
      own      = -1;
      used     = 0;
      last     = RN - 1;
      gnt      = 0;
      last_out = '0;
      hold     = '0;
      outq.delete();
   endtask

   task automatic step();
      bit free;
      #1;
      free    = (outq.size() == 0) || crdy;
      exp_rdy = '0;
      if (own >= 0 && free) exp_rdy[own] = 1'b1;
      chk("ready", rdy, exp_rdy);
      chk("cvalid", cvld, outq.size() != 0);
      chk("cdata", cdat, last_out);
      chk("gnt_id", gid, gnt);
      chk("busy", busy, own >= 0 || outq.size() != 0);
      for (int k = 0; k < RN; k++) begin
         hold[k] = vld[k] && !exp_rdy[k];
         if (vld[k] && exp_rdy[k]) hs_cnt[k]++;
      end
      if (crdy && outq.size() != 0) void'(outq.pop_front());
      if (own >= 0) begin
         if (vld[own] && free) begin
            last_out = {IW'(own), dat[own*DW +: DW]};
            outq.push_back(last_out);
            used++;
            if (used == MB) begin
               last = own;
               own  = -1;
            end
         end else if (!vld[own]) begin
            last = own;
            own  = -1;
         end
      end else if (vld != '0) begin
         for (int i = 1; i <= RN; i++) begin
            int k;
            k = (last + i) % RN;
            if (vld[k]) begin
               own  = k;
               gnt  = k;
               used = 0;
               break;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic rand_inputs(input logic [RN-1:0] mask, input int vpct);
      for (int k = 0; k < RN; k++) begin
         if (!hold[k]) begin
            vld[k] = mask[k] && ($urandom_range(99) < vpct);
            dat[k*DW +: DW] = $urandom();
         end
      end
   endtask

   task automatic quiesce();
      repeat (12) begin
         for (int k = 0; k < RN; k++) if (!hold[k]) vld[k] = 1'b0;
         crdy = 1'b1;
         step();
      end
   endtask

   int base;

   initial begin
      vld  = '0;
      dat  = '0;
      crdy = 1'b0;
      for (int k = 0; k < RN; k++) hs_cnt[k] = 0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", rdy, 0);
      chk("rst_cvalid", cvld, 0);
      chk("rst_cdata", cdat, 0);
      chk("rst_gnt", gid, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester 2 with fixed payload.
      vld = 4'b0100;
      dat[2*DW +: DW] = 32'hA5;
      crdy = 1'b1;
      step();
      #1 chk("t1_ready", rdy, 4'b0100);
      step();
      #1 chk("t1_cvalid", cvld, 1);
      chk("t1_cdata", cdat, {2'd2, 32'hA5});
      vld = '0;
      step();
      quiesce();

      // Requester 1 for six beats: a burst of four, then two more.
      base = hs_cnt[1];
      repeat (30) begin
         if (!hold[1]) begin
            vld[1] = (hs_cnt[1] - base) < 6;
            dat[DW +: DW] = $urandom();
         end
         step();
      end
      chk("t3_beats", hs_cnt[1] - base, 6);
      quiesce();

      // Output register stalled for five cycles.
      vld = 4'b0001;
      dat[0 +: DW] = $urandom();
      step();
      step();
      crdy = 1'b0;
      repeat (5) begin
         rand_inputs(4'b0001, 100);
         #1 chk("t4_stall_ready", rdy, 0);
         step();
      end
      crdy = 1'b1;
      repeat (6) begin
         rand_inputs(4'b0001, 100);
         step();
      end
      quiesce();

      // Reset with a beat pending in the output register.
      vld = 4'b1111;
      dat = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      step();
      crdy = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cvalid", cvld, 0);
      chk("mid_rst_ready", rdy, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cdata", cdat, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      crdy = 1'b1;
      vld = 4'b0011;

      // Requester 0 drops after two beats; requester 1 takes over.
      base = hs_cnt[0];
      step();
      #1 chk("rst_prio", rdy, 4'b0001);
      repeat (8) begin
         if (!hold[0]) vld[0] = (hs_cnt[0] - base) < 2;
         step();
      end
      chk("t5_beats0", hs_cnt[0] - base, 2);
      chk("t5_gnt", gid, 1);
      quiesce();

      // All four continuously valid, sink always ready.
      vld = 4'b1111;
      repeat (40) begin
         rand_inputs(4'b1111, 100);
         step();
      end
      quiesce();

      // Randomized traffic.
      for (int p = 0; p < 10; p++) begin
         logic [RN-1:0] mask;
         int vpct;
         int rpct;
         mask = RN'($urandom_range(1, 15));
         vpct = $urandom_range(30, 100);
         rpct = $urandom_range(20, 100);
         repeat (200) begin
            rand_inputs(mask, vpct);
            crdy = $urandom_range(99) < rpct;
            step();
         end
      end
      quiesce();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
